// File: rtl/serial_cmd_engine.sv
// Byte-command engine: decodes UART opcodes, gathers arguments, updates
// PLL/control outputs and streams replies (version, status, histogram).
// Ports: clk/reset (sync, active-high); rxReady/rxData in from UART RX;
// txBusy in, txStart/txData out to UART TX; h in, resethist out for the
// histogrammer; locked in, pll_shifts/updatepll out for the PLL;
// disable_line_drivers, enable_debug_outputs, ctrl_regs, status outputs.
module serial_cmd_engine #(
    parameter int         NUM_HIST    = 32,
    parameter int         HIST_W      = 32,
    parameter int         NUM_PLL     = 6,
    parameter int         NUM_REGS    = 4,
    parameter int         TIMEOUT_CYC = 1000000,
    parameter logic [7:0] VERSION     = 8'd24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rxReady,
    input  logic [7:0]                   rxData,
    input  logic                         txBusy,
    output logic                         txStart,
    output logic [7:0]                   txData,
    input  logic [NUM_HIST*HIST_W-1:0]   h,
    output logic                         resethist,
    input  logic                         locked,
    output logic [NUM_PLL*8-1:0]         pll_shifts,
    output logic                         updatepll,
    output logic                         disable_line_drivers,
    output logic                         enable_debug_outputs,
    output logic [NUM_REGS*8-1:0]        ctrl_regs,
    output logic [2:0]                   status
);
    localparam int HWID = NUM_HIST * HIST_W;
    localparam int HB   = HWID / 8;
    localparam int MAXA = (NUM_PLL > 2) ? NUM_PLL : 2;
    localparam int AW   = $clog2(MAXA);
    localparam int RW   = $clog2(HB + 1);
    localparam int TW   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    NREG8   = 8'(NUM_REGS);

    localparam logic [3:0] OP_VER  = 4'd0;
    localparam logic [3:0] OP_OUT  = 4'd1;
    localparam logic [3:0] OP_PLL  = 4'd2;
    localparam logic [3:0] OP_HIST = 4'd3;
    localparam logic [3:0] OP_STAT = 4'd4;
    localparam logic [3:0] OP_REG  = 4'd5;
    localparam logic [3:0] OP_RST  = 4'd6;
    // Internal code for a rejected command byte; replies 0xEE.
    localparam logic [3:0] OP_BAD  = 4'hF;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARGS   = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_SEND   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_PLLUPD = 3'd5;

    logic [2:0]      state;
    logic [3:0]      op;
    logic [7:0]      args [0:(1<<AW)-1];
    logic [AW-1:0]   acnt;
    logic [TW-1:0]   tcnt;
    logic [RW-1:0]   rem;
    logic [HWID-1:0] shadow;

    logic       rx_bad;
    logic       fire;
    logic       idle_to;
    logic       st_clr;
    logic [2:0] st_set;
    logic [7:0] tx_byte;

    function automatic logic has_args(input logic [3:0] o);
        return (o == OP_OUT) || (o == OP_PLL) || (o == OP_REG);
    endfunction

    // Index of the final argument byte for opcodes that take arguments.
    function automatic logic [AW-1:0] last_idx(input logic [3:0] o);
        logic [AW-1:0] r;
        r = '0;
        if (o == OP_PLL) r = AW'(NUM_PLL - 1);
        if (o == OP_REG) r = AW'(1);
        return r;
    endfunction

    assign rx_bad  = (rxData[7:4] != 4'd0) || (rxData[3:0] >= 4'd7);
    assign fire    = (state == S_SEND) && !txBusy && !reset;
    assign idle_to = (state == S_ARGS) && !rxReady && (tcnt == TO_LAST);
    assign st_clr  = fire && (op == OP_STAT);

    always_comb begin
        tx_byte = 8'hEE;
        unique case (1'b1)
            op == OP_VER:  tx_byte = VERSION;
            op == OP_STAT: tx_byte = {5'b0, status};
            op == OP_HIST: tx_byte = shadow[7:0];
            default:       tx_byte = 8'hEE;
        endcase
    end

    always_comb begin
        st_set    = 3'b000;
        st_set[0] = !locked;
        st_set[1] = idle_to;
        if (state == S_IDLE && rxReady && rx_bad)
            st_set[2] = 1'b1;
        if (state == S_EXEC && op == OP_REG && args[0] >= NREG8)
            st_set[2] = 1'b1;
    end

    // Strobes are gated by reset so nothing escapes during the reset cycle.
    assign txStart   = fire;
    assign txData    = fire ? tx_byte : 8'h00;
    assign resethist = (state == S_EXEC) && (op == OP_HIST) && !reset;
    assign updatepll = (state == S_PLLUPD) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= S_IDLE;
            op                   <= OP_VER;
            acnt                 <= '0;
            tcnt                 <= '0;
            rem                  <= '0;
            pll_shifts           <= '0;
            ctrl_regs            <= '0;
            status               <= '0;
            disable_line_drivers <= 1'b0;
            enable_debug_outputs <= 1'b0;
        end else begin
            // A new event wins over a same-cycle clear.
            status <= (status & ~{3{st_clr}}) | st_set;
            unique case (state)
                S_IDLE: begin
                    if (rxReady) begin
                        acnt <= '0;
                        tcnt <= '0;
                        if (rx_bad) begin
                            op    <= OP_BAD;
                            state <= S_EXEC;
                        end else begin
                            op    <= rxData[3:0];
                            state <= has_args(rxData[3:0]) ? S_ARGS : S_EXEC;
                        end
                    end
                end
                S_ARGS: begin
                    if (rxReady) begin
                        args[acnt] <= rxData;
                        acnt       <= acnt + 1'b1;
                        tcnt       <= '0;
                        if (acnt == last_idx(op))
                            state <= S_EXEC;
                    end else if (idle_to) begin
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    state <= S_IDLE;
                    unique case (1'b1)
                        op == OP_OUT: begin
                            disable_line_drivers <= !args[0][0];
                            enable_debug_outputs <= args[0][1];
                        end
                        op == OP_PLL: begin
                            for (int i = 0; i < NUM_PLL; i++)
                                pll_shifts[i*8 +: 8] <= args[AW'(i)];
                            state <= S_PLLUPD;
                        end
                        op == OP_RST: begin
                            pll_shifts <= '0;
                            state      <= S_PLLUPD;
                        end
                        op == OP_REG: begin
                            for (int i = 0; i < NUM_REGS; i++)
                                if (args[0] == 8'(i))
                                    ctrl_regs[i*8 +: 8] <= args[1];
                        end
                        op == OP_HIST: begin
                            shadow <= h;
                            rem    <= RW'(HB);
                            state  <= S_SEND;
                        end
                        default: begin
                            rem   <= RW'(1);
                            state <= S_SEND;
                        end
                    endcase
                end
                S_SEND: begin
                    if (!txBusy) begin
                        rem    <= rem - 1'b1;
                        shadow <= shadow >> 8;
                        state  <= S_GAP;
                    end
                end
                S_GAP: begin
                    state <= (rem != '0) ? S_SEND : S_IDLE;
                end
                S_PLLUPD: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_cmd_engine.sv
// Randomised bench for serial_cmd_engine against a command-level model:
// expected reply byte queue plus expected output/status registers.
module tb_serial_cmd_engine;
    localparam int NH  = 2;
    localparam int HWD = 16;
    localparam int NP  = 6;
    localparam int NR  = 4;
    localparam int TO  = 40;
    localparam int NB  = NH * HWD / 8;
    localparam logic [7:0] VER = 8'd24;

    logic              clk = 1'b0;
    logic              reset;
    logic              rxReady;
    logic [7:0]        rxData;
    logic              txBusy;
    logic              txStart;
    logic [7:0]        txData;
    logic [NH*HWD-1:0] h;
    logic              resethist;
    logic              locked;
    logic [NP*8-1:0]   pll_shifts;
    logic              updatepll;
    logic              dld;
    logic              edo;
    logic [NR*8-1:0]   ctrl_regs;
    logic [2:0]        status;

    logic [7:0]      exp_q [$];
    logic [NP*8-1:0] m_pll;
    logic [NR*8-1:0] m_ctrl;
    logic            m_dld;
    logic            m_edo;
    logic [2:0]      m_status;
    logic            model_valid = 1'b0;
    logic            busy_rand = 1'b0;
    logic            busy_force = 1'b0;
    int              errors = 0;
    int              checks = 0;
    int              upd_cnt = 0;
    int              rh_cnt = 0;

    serial_cmd_engine #(
        .NUM_HIST(NH), .HIST_W(HWD), .NUM_PLL(NP),
        .NUM_REGS(NR), .TIMEOUT_CYC(TO), .VERSION(VER)
    ) dut (
        .clk(clk), .reset(reset),
        .rxReady(rxReady), .rxData(rxData),
        .txBusy(txBusy), .txStart(txStart), .txData(txData),
        .h(h), .resethist(resethist),
        .locked(locked), .pll_shifts(pll_shifts),
        .updatepll(updatepll),
        .disable_line_drivers(dld),
        .enable_debug_outputs(edo),
        .ctrl_regs(ctrl_regs), .status(status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Sole writer of txBusy.
    initial begin
        txBusy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (busy_force) txBusy = 1'b1;
            else if (busy_rand) txBusy = ($urandom_range(0, 3) == 0);
            else txBusy = 1'b0;
        end
    end

    // Compare process: every negedge.
    always @(negedge clk) begin
        if (resethist === 1'b1) rh_cnt++;
        if (updatepll === 1'b1) upd_cnt++;
        if (txStart === 1'b1) begin
            chk("txStart_while_busy", 64'(txBusy), 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx: got %0h required none",
                         txData);
            end else begin
                chk("txData", 64'(txData), 64'(exp_q.pop_front()));
            end
        end
        if (model_valid) begin
            chk("pll_shifts", 64'(pll_shifts), 64'(m_pll));
            chk("ctrl_regs", 64'(ctrl_regs), 64'(m_ctrl));
            chk("disable_line_drivers", 64'(dld), 64'(m_dld));
            chk("enable_debug_outputs", 64'(edo), 64'(m_edo));
            chk("status", 64'(status), 64'(m_status));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rxReady = 1'b1;
        rxData  = b;
        @(posedge clk);
        #1;
        rxReady = 1'b0;
        rxData  = 8'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            cyc(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reply_timeout: %0d bytes pending, required 0",
                     exp_q.size());
            exp_q.delete();
        end
        cyc(3);
        model_valid = 1'b1;
    endtask

    task automatic do_version();
        model_valid = 1'b0;
        exp_q.push_back(VER);
        send_byte(8'h00);
        wait_done();
    endtask

    task automatic do_bad(input logic [7:0] b);
        model_valid = 1'b0;
        exp_q.push_back(8'hEE);
        m_status[2] = 1'b1;
        send_byte(b);
        wait_done();
    endtask

    task automatic do_status(input bit push);
        model_valid = 1'b0;
        if (push) exp_q.push_back({5'b0, m_status});
        m_status = 3'b000;
        send_byte(8'h04);
        wait_done();
    endtask

    task automatic do_outputs(input logic [7:0] a);
        model_valid = 1'b0;
        send_byte(8'h01);
        cyc($urandom_range(0, 2));
        send_byte(a);
        m_dld = !a[0];
        m_edo = a[1];
        wait_done();
    endtask

    task automatic do_reg(input int idx, input logic [7:0] v,
                          input int gap);
        model_valid = 1'b0;
        send_byte(8'h05);
        send_byte(8'(idx));
        cyc(gap);
        send_byte(v);
        if (idx < NR) m_ctrl[idx*8 +: 8] = v;
        else m_status[2] = 1'b1;
        wait_done();
    endtask

    task automatic do_pll(input logic [NP*8-1:0] v, input bit rst);
        int u0;
        model_valid = 1'b0;
        if (rst) begin
            send_byte(8'h06);
            m_pll = '0;
        end else begin
            send_byte(8'h02);
            for (int i = 0; i < NP; i++) begin
                if (i != 0) cyc($urandom_range(0, 2));
                send_byte(v[i*8 +: 8]);
            end
            m_pll = v;
        end
        u0 = upd_cnt;
        @(negedge clk);
        chk("updatepll_exec", 64'(updatepll), 64'd0);
        @(negedge clk);
        chk("updatepll", 64'(updatepll), 64'd1);
        chk("pll_at_update", 64'(pll_shifts), 64'(m_pll));
        @(negedge clk);
        chk("updatepll_after", 64'(updatepll), 64'd0);
        chk("updatepll_cycles", 64'(upd_cnt - u0), 64'd1);
        @(posedge clk);
        #1;
        wait_done();
    endtask

    task automatic do_hist(input logic [NH*HWD-1:0] v, input bit push,
                           input int hold);
        int r0;
        logic [HWD-1:0] bin;
        model_valid = 1'b0;
        if (push) begin
            for (int k = 0; k < NH; k++) begin
                bin = v[k*HWD +: HWD];
                for (int j = 0; j < HWD / 8; j++)
                    exp_q.push_back(bin[j*8 +: 8]);
            end
        end
        if (hold > 0) busy_force = 1'b1;
        h  = v;
        r0 = rh_cnt;
        send_byte(8'h03);
        @(negedge clk);
        chk("resethist_exec", 64'(resethist), 64'd1);
        @(posedge clk);
        #1;
        h = ~v ^ (NH*HWD)'($urandom);
        if (hold > 0) begin
            cyc(hold);
            chk("busy_pending", 64'(exp_q.size()), 64'(NB));
            busy_force = 1'b0;
        end
        wait_done();
        chk("resethist_pulses", 64'(rh_cnt - r0), 64'd1);
    endtask

    task automatic do_timeout(input logic [7:0] opb, input int given);
        model_valid = 1'b0;
        send_byte(opb);
        for (int i = 0; i < given; i++) send_byte(8'($urandom));
        cyc(TO);
        m_status[1] = 1'b1;
        model_valid = 1'b1;
        cyc(1);
    endtask

    task automatic do_lock(input int n);
        model_valid = 1'b0;
        locked = 1'b0;
        cyc(n);
        locked = 1'b1;
        m_status[0] = 1'b1;
        cyc(2);
        model_valid = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int sel;
        int u0;
        reset   = 1'b1;
        rxReady = 1'b0;
        rxData  = 8'h00;
        locked  = 1'b1;
        h       = '0;
        m_pll = '0; m_ctrl = '0; m_dld = 0; m_edo = 0; m_status = '0;
        cyc(3);
        @(negedge clk);
        chk("rst_txStart", 64'(txStart), 64'd0);
        chk("rst_txData", 64'(txData), 64'd0);
        chk("rst_resethist", 64'(resethist), 64'd0);
        chk("rst_updatepll", 64'(updatepll), 64'd0);
        chk("rst_pll", 64'(pll_shifts), 64'd0);
        chk("rst_ctrl", 64'(ctrl_regs), 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_dld", 64'(dld), 64'd0);
        chk("rst_edo", 64'(edo), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(2);
        model_valid = 1'b1;

        // Version reply, literal 0x18.
        model_valid = 1'b0;
        exp_q.push_back(8'h18);
        send_byte(8'h00);
        wait_done();

        do_pll(48'h060504030201, 1'b0);
        chk("pll_literal", 64'(pll_shifts), 64'h060504030201);

        // Bad byte then two status reads.
        do_bad(8'h0F);
        exp_q.push_back(8'h04);
        do_status(1'b0);
        exp_q.push_back(8'h00);
        do_status(1'b0);

        // Partial SET_REG times out.
        do_reg(1, 8'h77, 0);
        do_timeout(8'h05, 1);
        chk("timeout_status", 64'(status), 64'b010);
        chk("timeout_ctrl", 64'(ctrl_regs), 64'h0000_7700);
        model_valid = 1'b0;
        exp_q.push_back(8'h18);
        send_byte(8'h00);
        wait_done();
        exp_q.push_back(8'h02);
        do_status(1'b0);

        // Last argument one cycle before the timeout still lands.
        do_reg(2, 8'h5A, TO - 1);
        chk("late_arg_ctrl", 64'(ctrl_regs), 64'h005A_7700);
        do_reg(4, 8'h33, 0);
        exp_q.push_back(8'h04);
        do_status(1'b0);

        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hBB);
        exp_q.push_back(8'hBB);
        do_hist(32'hBBBBAAAA, 1'b0, 0);
        do_hist(32'h44332211, 1'b1, 50);
        do_outputs(8'h02);

        busy_rand = 1'b1;
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 10);
            case (k)
                0, 10: do_version();
                1: do_outputs(8'($urandom));
                2: do_pll({16'($urandom), 32'($urandom)}, 1'b0);
                3: do_hist(32'($urandom), 1'b1, 0);
                4: do_status(1'b1);
                5: do_reg($urandom_range(0, 5), 8'($urandom),
                          $urandom_range(0, 3));
                6: do_pll('0, 1'b1);
                7: begin
                    if ($urandom_range(0, 1) == 0)
                        do_bad(8'($urandom_range(7, 15)));
                    else
                        do_bad(8'($urandom_range(16, 255)));
                end
                8: do_lock($urandom_range(1, 4));
                default: begin
                    sel = $urandom_range(0, 2);
                    if (sel == 0) do_timeout(8'h01, 0);
                    else if (sel == 1)
                        do_timeout(8'h02, $urandom_range(0, NP - 1));
                    else do_timeout(8'h05, $urandom_range(0, 1));
                end
            endcase
        end
        busy_rand = 1'b0;
        do_status(1'b1);

        // Reset while a reply waits on txBusy: nothing may go out.
        do_pll(48'h0A0B0C0D0E0F, 1'b0);
        do_reg(3, 8'hC3, 0);
        model_valid = 1'b0;
        busy_force = 1'b1;
        send_byte(8'h03);
        cyc(5);
        reset = 1'b1;
        busy_force = 1'b0;
        cyc(2);
        reset = 1'b0;
        m_pll = '0; m_ctrl = '0; m_dld = 0; m_edo = 0; m_status = '0;
        model_valid = 1'b1;
        cyc(20);
        chk("post_rst_pll", 64'(pll_shifts), 64'd0);

        // Reset mid-argument: args abandoned, counter cleared.
        model_valid = 1'b0;
        u0 = upd_cnt;
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        exp_q.push_back(8'h18);
        send_byte(8'h00);
        wait_done();
        chk("midarg_pll", 64'(pll_shifts), 64'd0);
        chk("midarg_upd", 64'(upd_cnt - u0), 64'd0);
        do_pll(48'h665544332211, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
